// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: BCD 24-hour HH:MM:SS counter with validated set handshake and HH:MM alarm
module rtc_timekeeper #(
    parameter logic [7:0] RESET_HH = 8'h00,
    parameter logic [7:0] RESET_MM = 8'h00,
    parameter logic [7:0] RESET_SS = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_err,
    input  logic       alarm_wr,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_en,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       alarm
);
    typedef enum logic {IDLE, CHECK} state_t;

    state_t     state_q, state_d;
    logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [7:0] hold_hh_q, hold_hh_d, hold_mm_q, hold_mm_d, hold_ss_q, hold_ss_d;
    logic [7:0] alarm_hh_q, alarm_hh_d, alarm_mm_q, alarm_mm_d;
    logic       set_ready_q, set_ready_d, set_err_q, set_err_d;
    logic       sec_pulse_q, sec_pulse_d, day_pulse_q, day_pulse_d, alarm_q, alarm_d;
    logic [7:0] nxt_hh, nxt_mm, nxt_ss;
    logic       ss_wrap, mm_wrap, set_ok, accept, commit, adv;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        return (v == 8'h59) ? 8'h00 : (v[3:0] == 4'h9) ? {v[7:4] + 4'd1, 4'h0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        return (v == 8'h23) ? 8'h00 : (v[3:0] == 4'h9) ? {v[7:4] + 4'd1, 4'h0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign ss_wrap = (ss_q == 8'h59);
    assign mm_wrap = (mm_q == 8'h59);
    assign nxt_ss  = inc60(ss_q);
    assign nxt_mm  = ss_wrap ? inc60(mm_q) : mm_q;
    assign nxt_hh  = (ss_wrap && mm_wrap) ? inc24(hh_q) : hh_q;

    // Legal 24-hour BCD: digits 0-9, hours up to 23, minute/second tens up to 5
    assign set_ok = (hold_hh_q[3:0] <= 4'h9) && (hold_hh_q <= 8'h23)
                 && (hold_mm_q[3:0] <= 4'h9) && (hold_mm_q[7:4] <= 4'h5)
                 && (hold_ss_q[3:0] <= 4'h9) && (hold_ss_q[7:4] <= 4'h5);

    // Next-state logic: set FSM, time advance/commit, alarm registers and pulses
    always_comb begin
        accept      = (state_q == IDLE) && set_valid && set_ready_q;
        commit      = (state_q == CHECK) && set_ok;
        adv         = tick && !commit;
        state_d     = (state_q == CHECK) ? IDLE : accept ? CHECK : IDLE;
        set_ready_d = (state_d == IDLE);
        set_err_d   = (state_q == CHECK) && !set_ok;
        hold_hh_d   = accept ? set_hh : hold_hh_q;
        hold_mm_d   = accept ? set_mm : hold_mm_q;
        hold_ss_d   = accept ? set_ss : hold_ss_q;
        alarm_hh_d  = alarm_wr ? alarm_hh : alarm_hh_q;
        alarm_mm_d  = alarm_wr ? alarm_mm : alarm_mm_q;
        hh_d        = commit ? hold_hh_q : adv ? nxt_hh : hh_q;
        mm_d        = commit ? hold_mm_q : adv ? nxt_mm : mm_q;
        ss_d        = commit ? hold_ss_q : adv ? nxt_ss : ss_q;
        sec_pulse_d = adv;
        day_pulse_d = adv && ss_wrap && mm_wrap && (hh_q == 8'h23);
        alarm_d     = adv && alarm_en && (nxt_hh == alarm_hh_q) && (nxt_mm == alarm_mm_q) && (nxt_ss == 8'h00);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            hh_q        <= RESET_HH;
            mm_q        <= RESET_MM;
            ss_q        <= RESET_SS;
            hold_hh_q   <= 8'h00;
            hold_mm_q   <= 8'h00;
            hold_ss_q   <= 8'h00;
            alarm_hh_q  <= 8'h00;
            alarm_mm_q  <= 8'h00;
            set_ready_q <= 1'b0;
            set_err_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            hold_hh_q   <= hold_hh_d;
            hold_mm_q   <= hold_mm_d;
            hold_ss_q   <= hold_ss_d;
            alarm_hh_q  <= alarm_hh_d;
            alarm_mm_q  <= alarm_mm_d;
            set_ready_q <= set_ready_d;
            set_err_q   <= set_err_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
            alarm_q     <= alarm_d;
        end
    end

    assign set_ready = set_ready_q;
    assign set_err   = set_err_q;
    assign hh        = hh_q;
    assign mm        = mm_q;
    assign ss        = ss_q;
    assign sec_pulse = sec_pulse_q;
    assign day_pulse = day_pulse_q;
    assign alarm     = alarm_q;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: directed scenario tests for rtc_timekeeper
module tb_rtc_timekeeper;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       set_valid = 1'b0;
    logic       set_ready;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
    logic       set_err;
    logic       alarm_wr = 1'b0;
    logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
    logic       alarm_en = 1'b0;
    logic [7:0] hh, mm, ss;
    logic       sec_pulse, day_pulse, alarm;
    logic [23:0] now_t;
    int checks = 0;
    int errors = 0;

    assign now_t = {hh, mm, ss};

    rtc_timekeeper dut (
        .clk(clk), .rst(rst), .tick(tick),
        .set_valid(set_valid), .set_ready(set_ready),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_err(set_err),
        .alarm_wr(alarm_wr), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_en(alarm_en),
        .hh(hh), .mm(mm), .ss(ss),
        .sec_pulse(sec_pulse), .day_pulse(day_pulse), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    // Wait for set_ready, present a request, optionally tick during CHECK, return just after the CHECK edge
    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic tk);
        int n = 0;
        while (!set_ready && n < 10) begin
            cyc();
            n++;
        end
        checks++;
        if (set_ready !== 1'b1) begin
            errors++;
            $display("FAIL set_ready_wait: set_ready=%b required 1", set_ready);
        end
        set_hh = h; set_mm = m; set_ss = s;
        set_valid = 1'b1;
        cyc();
        set_valid = 1'b0;
        tick = tk;
        cyc();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) cyc();
        checks++;
        if (now_t !== 24'h000000 || set_ready !== 1'b0 || set_err !== 1'b0 || sec_pulse !== 1'b0 || day_pulse !== 1'b0 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: time=%h rdy=%b err=%b sec=%b day=%b alm=%b required 000000 0 0 0 0 0", now_t, set_ready, set_err, sec_pulse, day_pulse, alarm);
        end
        rst = 1'b1;
        cyc();
        checks++;
        if (set_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: set_ready=%b required 1", set_ready);
        end
    endtask

    task automatic test_ticks();
        for (int i = 1; i <= 3; i++) begin
            do_tick();
            checks++;
            if (sec_pulse !== 1'b1 || now_t !== 24'(i)) begin
                errors++;
                $display("FAIL tick_%0d: sec=%b time=%h required 1 %h", i, sec_pulse, now_t, 24'(i));
            end
            cyc();
            checks++;
            if (sec_pulse !== 1'b0) begin
                errors++;
                $display("FAIL tick_%0d_pulse_width: sec=%b required 0", i, sec_pulse);
            end
            repeat (3) cyc();
        end
        checks++;
        if (now_t !== 24'h000003) begin
            errors++;
            $display("FAIL three_ticks: time=%h required 000003", now_t);
        end
    endtask

    task automatic test_rollover();
        do_set(8'h23, 8'h59, 8'h58, 1'b0);
        checks++;
        if (now_t !== 24'h235958 || sec_pulse !== 1'b0 || set_err !== 1'b0 || set_ready !== 1'b1) begin
            errors++;
            $display("FAIL set_235958: time=%h sec=%b err=%b rdy=%b required 235958 0 0 1", now_t, sec_pulse, set_err, set_ready);
        end
        do_tick();
        checks++;
        if (now_t !== 24'h235959 || day_pulse !== 1'b0 || sec_pulse !== 1'b1) begin
            errors++;
            $display("FAIL tick_235959: time=%h day=%b sec=%b required 235959 0 1", now_t, day_pulse, sec_pulse);
        end
        do_tick();
        checks++;
        if (now_t !== 24'h000000 || day_pulse !== 1'b1 || sec_pulse !== 1'b1) begin
            errors++;
            $display("FAIL day_rollover: time=%h day=%b sec=%b required 000000 1 1", now_t, day_pulse, sec_pulse);
        end
        cyc();
        checks++;
        if (day_pulse !== 1'b0) begin
            errors++;
            $display("FAIL day_pulse_width: day=%b required 0", day_pulse);
        end
    endtask

    task automatic test_invalid_set();
        logic [23:0] bad [3];
        bad[0] = 24'h127500;
        bad[1] = 24'h240000;
        bad[2] = 24'h00000A;
        for (int i = 0; i < 3; i++) begin
            do_set(bad[i][23:16], bad[i][15:8], bad[i][7:0], 1'b0);
            checks++;
            if (set_err !== 1'b1 || now_t !== 24'h000000 || set_ready !== 1'b1) begin
                errors++;
                $display("FAIL invalid_%h: err=%b time=%h rdy=%b required 1 000000 1", bad[i], set_err, now_t, set_ready);
            end
            cyc();
            checks++;
            if (set_err !== 1'b0) begin
                errors++;
                $display("FAIL invalid_%h_err_width: err=%b required 0", bad[i], set_err);
            end
        end
        do_set(8'h12, 8'h75, 8'h00, 1'b1);
        checks++;
        if (set_err !== 1'b1 || now_t !== 24'h000001 || sec_pulse !== 1'b1) begin
            errors++;
            $display("FAIL invalid_with_tick: err=%b time=%h sec=%b required 1 000001 1", set_err, now_t, sec_pulse);
        end
    endtask

    task automatic test_tick_in_check();
        do_set(8'h10, 8'h00, 8'h00, 1'b1);
        checks++;
        if (now_t !== 24'h100000 || sec_pulse !== 1'b0 || set_err !== 1'b0) begin
            errors++;
            $display("FAIL tick_in_check: time=%h sec=%b err=%b required 100000 0 0", now_t, sec_pulse, set_err);
        end
        do_tick();
        checks++;
        if (now_t !== 24'h100001 || sec_pulse !== 1'b1) begin
            errors++;
            $display("FAIL tick_after_set: time=%h sec=%b required 100001 1", now_t, sec_pulse);
        end
    endtask

    task automatic test_alarm();
        alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_wr = 1'b1;
        cyc();
        alarm_wr = 1'b0;
        alarm_en = 1'b1;
        do_set(8'h07, 8'h29, 8'h59, 1'b0);
        do_tick();
        checks++;
        if (now_t !== 24'h073000 || alarm !== 1'b1 || sec_pulse !== 1'b1) begin
            errors++;
            $display("FAIL alarm_hit: time=%h alarm=%b sec=%b required 073000 1 1", now_t, alarm, sec_pulse);
        end
        cyc();
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_width: alarm=%b required 0", alarm);
        end
        alarm_en = 1'b0;
        do_set(8'h07, 8'h29, 8'h59, 1'b0);
        do_tick();
        checks++;
        if (now_t !== 24'h073000 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_disabled: time=%h alarm=%b required 073000 0", now_t, alarm);
        end
        alarm_en = 1'b1;
        do_set(8'h07, 8'h30, 8'h00, 1'b0);
        checks++;
        if (now_t !== 24'h073000 || alarm !== 1'b0 || sec_pulse !== 1'b0) begin
            errors++;
            $display("FAIL alarm_on_set: time=%h alarm=%b sec=%b required 073000 0 0", now_t, alarm, sec_pulse);
        end
        alarm_en = 1'b0;
    endtask

    task automatic test_reset_in_check();
        set_hh = 8'h05; set_mm = 8'h05; set_ss = 8'h05;
        set_valid = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (now_t !== 24'h000000 || set_err !== 1'b0 || set_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_check: time=%h err=%b rdy=%b required 000000 0 0", now_t, set_err, set_ready);
        end
        rst = 1'b1;
        cyc();
        checks++;
        if (set_ready !== 1'b1 || set_err !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_abort: rdy=%b err=%b required 1 0", set_ready, set_err);
        end
        cyc();
        set_valid = 1'b0;
        checks++;
        if (set_ready !== 1'b0) begin
            errors++;
            $display("FAIL held_valid_accept: rdy=%b required 0", set_ready);
        end
        cyc();
        checks++;
        if (now_t !== 24'h050505 || set_err !== 1'b0 || set_ready !== 1'b1) begin
            errors++;
            $display("FAIL held_valid_commit: time=%h err=%b rdy=%b required 050505 0 1", now_t, set_err, set_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_t [3];
        exp_t[0] = 24'h050506;
        exp_t[1] = 24'h050507;
        exp_t[2] = 24'h050508;
        tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (now_t !== exp_t[i] || sec_pulse !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back_%0d: time=%h sec=%b required %h 1", i, now_t, sec_pulse, exp_t[i]);
            end
        end
        tick = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cyc();
        test_reset();
        test_ticks();
        test_rollover();
        test_invalid_set();
        test_tick_in_check();
        test_alarm();
        test_reset_in_check();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
